// File: rtl/shared_mem_lsu.sv
// Warp load/store initiator for the banked shared memory: splits lane addresses
// into bank/row, serializes bank conflicts and returns one warp response.
module shared_mem_lsu #(
  parameter int LANES         = 4,
  parameter int NUM_BANKS     = 4,
  parameter int BANK_BITS     = 2,
  parameter int BLOCK_SIZE    = 32,
  parameter int ADDRESS_WIDTH = 5,
  parameter int DATA_WIDTH    = 16
) (
  input  logic                                         clk,
  input  logic                                         rst_n,
  input  logic                                         req_valid,
  output logic                                         req_ready,
  input  logic                                         req_store,
  input  logic [LANES-1:0]                             req_mask,
  input  logic [LANES*(ADDRESS_WIDTH+BANK_BITS)-1:0]   req_addr,
  input  logic [LANES*DATA_WIDTH-1:0]                  req_wdata,
  output logic                                         resp_valid,
  input  logic                                         resp_ready,
  output logic [LANES*DATA_WIDTH-1:0]                  resp_rdata,
  output logic [7:0]                                   resp_cycles,
  output logic [NUM_BANKS-1:0]                         bank_write_en,
  output logic [NUM_BANKS*ADDRESS_WIDTH-1:0]           bank_addr,
  output logic [NUM_BANKS*DATA_WIDTH-1:0]              bank_write_data,
  input  logic [NUM_BANKS*DATA_WIDTH-1:0]              bank_read_data
);
  localparam int LAW = ADDRESS_WIDTH + BANK_BITS;

  if (BLOCK_SIZE > (1 << ADDRESS_WIDTH)) begin : g_bad_block_size
    $error("BLOCK_SIZE does not fit in ADDRESS_WIDTH row bits");
  end

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; valid never depends on ready, and a response holds until taken.
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, RESP} state_t;
  state_t state, state_next;

  logic                                  is_store;
  logic [LANES-1:0]                      pending, cap_mask, grant;
  logic [LANES-1:0][LAW-1:0]             lane_addr;
  logic [LANES-1:0][DATA_WIDTH-1:0]      lane_wdata, rdata_q;
  logic [NUM_BANKS-1:0][DATA_WIDTH-1:0]  brd;
  logic [7:0]                            cycles_q;
  logic [NUM_BANKS-1:0]                  win_valid;
  logic [NUM_BANKS-1:0][ADDRESS_WIDTH-1:0] win_row;
  logic [NUM_BANKS-1:0][DATA_WIDTH-1:0]  win_data;

  assign brd = bank_read_data;

  // Per bank the lowest pending lane wins; loads also grant same-row lanes.
  always_comb begin
    grant     = '0;
    win_valid = '0;
    win_row   = '0;
    win_data  = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      for (int l = 0; l < LANES; l++) begin
        if (pending[l] && lane_addr[l][BANK_BITS-1:0] == BANK_BITS'(b)) begin
          if (!win_valid[b]) begin
            win_valid[b] = 1'b1;
            win_row[b]   = lane_addr[l][LAW-1:BANK_BITS];
            win_data[b]  = lane_wdata[l];
            grant[l]     = 1'b1;
          end else if (!is_store && lane_addr[l][LAW-1:BANK_BITS] == win_row[b]) begin
            grant[l] = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:  if (req_valid) state_next = (req_mask == '0) ? RESP : ISSUE;
      ISSUE: if ((pending & ~grant) == '0) state_next = is_store ? RESP : DRAIN;
      DRAIN: state_next = RESP;
      RESP:  if (resp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    req_ready       = (state == IDLE);
    resp_valid      = (state == RESP);
    resp_rdata      = rdata_q;
    resp_cycles     = cycles_q;
    bank_write_en   = '0;
    bank_addr       = '0;
    bank_write_data = '0;
    if (state == ISSUE) begin
      for (int b = 0; b < NUM_BANKS; b++) begin
        if (win_valid[b]) begin
          bank_addr[b*ADDRESS_WIDTH +: ADDRESS_WIDTH] = win_row[b];
          if (is_store) begin
            bank_write_en[b]                          = 1'b1;
            bank_write_data[b*DATA_WIDTH +: DATA_WIDTH] = win_data[b];
          end
        end
      end
    end
  end

  // Read data arrives one cycle after the grant, so captures lag by one cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      is_store   <= 1'b0;
      pending    <= '0;
      cap_mask   <= '0;
      lane_addr  <= '0;
      lane_wdata <= '0;
      rdata_q    <= '0;
      cycles_q   <= '0;
    end else begin
      for (int l = 0; l < LANES; l++) begin
        if (cap_mask[l]) rdata_q[l] <= brd[lane_addr[l][BANK_BITS-1:0]];
      end
      cap_mask <= '0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            is_store   <= req_store;
            pending    <= req_mask;
            lane_addr  <= req_addr;
            lane_wdata <= req_wdata;
            rdata_q    <= '0;
            cycles_q   <= '0;
          end
        end
        ISSUE: begin
          pending <= pending & ~grant;
          if (cycles_q != 8'hFF) cycles_q <= cycles_q + 8'd1;
          if (!is_store) cap_mask <= grant;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_shared_mem_lsu.sv
// Random and directed warp requests against a word-addressed memory model;
// a small bank array answers the DUT's bank ports with one-cycle read latency.
module tb_shared_mem_lsu;
  localparam int LANES = 4, NB = 4, BB = 2, BS = 32, AW = 5, DW = 16, LAW = 7;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic                 req_valid = 1'b0, req_ready, req_store = 1'b0;
  logic [LANES-1:0]     req_mask = '0;
  logic [LANES*LAW-1:0] req_addr = '0;
  logic [LANES*DW-1:0]  req_wdata = '0;
  logic                 resp_valid, resp_ready = 1'b0;
  logic [LANES*DW-1:0]  resp_rdata;
  logic [7:0]           resp_cycles;
  logic [NB-1:0]        bank_write_en;
  logic [NB*AW-1:0]     bank_addr;
  logic [NB*DW-1:0]     bank_write_data, bank_read_data;
  logic [NB-1:0][DW-1:0] brd_q;

  shared_mem_lsu dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_store(req_store), .req_mask(req_mask), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_cycles(resp_cycles),
    .bank_write_en(bank_write_en), .bank_addr(bank_addr),
    .bank_write_data(bank_write_data), .bank_read_data(bank_read_data)
  );

  // Bank array: registered read of the presented row, write on enable.
  logic [DW-1:0] mem [NB][BS];
  assign bank_read_data = brd_q;
  always @(posedge clk) begin
    for (int b = 0; b < NB; b++) begin
      brd_q[b] <= mem[b][bank_addr[b*AW +: AW]];
      if (bank_write_en[b]) mem[b][bank_addr[b*AW +: AW]] <= bank_write_data[b*DW +: DW];
    end
  end

  // Reference: flat word memory, indexed by the full lane address.
  logic [DW-1:0] gm [128];
  logic [DW-1:0] exp_q [$];
  logic [AW-1:0] b0_seq [$];
  int n_checks = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic report();
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  endtask

  task automatic run_req(input logic st, input logic [3:0] mask, input logic [6:0] a[4],
                         input logic [15:0] d[4], input int hold);
    int cyc, nb_act, k, wr_cycles, max_pop, exp_lat;
    int bank_cnt[NB];
    logic [NB-1:0] banks_seen;
    logic [63:0] exp_rd;
    bit uniq;
    cyc = 0; wr_cycles = 0; max_pop = 0; exp_rd = '0; banks_seen = '0;
    for (int b = 0; b < NB; b++) bank_cnt[b] = 0;
    for (int l = 0; l < LANES; l++) begin
      if (mask[l]) begin
        banks_seen[a[l] % NB] = 1'b1;
        uniq = 1'b1;
        for (int l2 = 0; l2 < l; l2++)
          if (mask[l2] && a[l2] == a[l]) uniq = 1'b0;
        if (st || uniq) bank_cnt[a[l] % NB]++;
        if (!st) exp_rd[l*DW +: DW] = gm[a[l]];
      end
    end
    for (int b = 0; b < NB; b++) if (bank_cnt[b] > cyc) cyc = bank_cnt[b];
    nb_act = $countones(banks_seen);
    exp_lat = (mask == 0) ? 1 : (st ? cyc + 1 : cyc + 2);
    exp_q.push_back(exp_rd[15:0]);

    @(negedge clk);
    check("req_ready_idle", 64'(req_ready), 64'd1);
    req_valid = 1'b1; req_store = st; req_mask = mask;
    for (int l = 0; l < LANES; l++) begin
      req_addr[l*LAW +: LAW] = a[l];
      req_wdata[l*DW +: DW]  = d[l];
    end
    @(posedge clk);
    b0_seq.delete();
    k = 0;
    forever begin
      @(negedge clk);
      req_valid = 1'b0;
      k++;
      if (k <= cyc) b0_seq.push_back(bank_addr[AW-1:0]);
      if (|bank_write_en) wr_cycles++;
      if ($countones(bank_write_en) > max_pop) max_pop = $countones(bank_write_en);
      if (resp_valid) break;
      if (k > 40) begin
        check("resp_timeout", 64'd0, 64'd1);
        report();
      end
    end
    check("latency", 64'(k), 64'(exp_lat));
    check("resp_cycles", 64'(resp_cycles), 64'(cyc));
    check("resp_rdata", resp_rdata, exp_rd);
    check("lane0_rdata", 64'(resp_rdata[15:0]), 64'(exp_q.pop_front()));
    check("write_cycles", 64'(wr_cycles), st ? 64'(cyc) : 64'd0);
    check("write_width", 64'(max_pop), st ? 64'(nb_act) : 64'd0);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check("hold_valid", 64'(resp_valid), 64'd1);
      check("hold_rdata", resp_rdata, exp_rd);
      check("hold_cycles", 64'(resp_cycles), 64'(cyc));
      check("hold_req_ready", 64'(req_ready), 64'd0);
      check("hold_bank_en", 64'(bank_write_en), 64'd0);
    end
    resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    resp_ready = 1'b0;
    check("resp_drop", 64'(resp_valid), 64'd0);
    if (st)
      for (int l = 0; l < LANES; l++) if (mask[l]) gm[a[l]] = d[l];
  endtask

  initial begin
    logic [6:0]  a[4];
    logic [15:0] d[4];
    for (int i = 0; i < 128; i++) gm[i] = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_req_ready", 64'(req_ready), 64'd1);
    check("rst_resp_valid", 64'(resp_valid), 64'd0);
    check("rst_rdata", resp_rdata, 64'd0);
    check("rst_cycles", 64'(resp_cycles), 64'd0);
    check("rst_bank_en", 64'(bank_write_en), 64'd0);
    check("rst_bank_addr", 64'(bank_addr), 64'd0);
    check("rst_bank_wdata", 64'(bank_write_data), 64'd0);
    rst_n = 1'b1;

    // Fill every word so the reference and the bank array agree.
    for (int r = 0; r < 32; r++) begin
      for (int l = 0; l < 4; l++) begin a[l] = 7'(4*r + l); d[l] = 16'($urandom); end
      run_req(1'b1, 4'hF, a, d, 0);
    end

    for (int l = 0; l < 4; l++) begin a[l] = 7'(l); d[l] = 16'(16'hA0 + l); end
    run_req(1'b1, 4'hF, a, d, 0);
    run_req(1'b0, 4'hF, a, d, 0);
    check("t2_rdata", resp_rdata, 64'h00A3_00A2_00A1_00A0);

    for (int l = 0; l < 4; l++) a[l] = 7'(4*l);
    run_req(1'b0, 4'hF, a, d, 0);
    check("b0_seq_len", 64'(b0_seq.size()), 64'd4);
    for (int i = 0; i < 4; i++)
      if (i < b0_seq.size()) check("b0_seq", 64'(b0_seq[i]), 64'(i));

    for (int l = 0; l < 4; l++) a[l] = 7'd5;
    run_req(1'b0, 4'hF, a, d, 0);

    a[0] = 7'd6; a[1] = 7'd6; a[2] = 7'd0; a[3] = 7'd0;
    d[0] = 16'h11; d[1] = 16'h22; d[2] = 16'h0; d[3] = 16'h0;
    run_req(1'b1, 4'b0011, a, d, 0);
    for (int l = 0; l < 4; l++) a[l] = 7'd6;
    run_req(1'b0, 4'hF, a, d, 0);
    check("t5_rdata", resp_rdata, {4{16'h0022}});

    run_req(1'b0, 4'h0, a, d, 5);

    for (int i = 0; i < 80; i++) begin
      for (int l = 0; l < 4; l++) begin
        if ($urandom_range(0, 1) == 1) a[l] = 7'($urandom_range(0, 127));
        else a[l] = 7'(($urandom_range(0, 2) << 2) | $urandom_range(0, 1));
        d[l] = 16'($urandom);
      end
      run_req(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), a, d, $urandom_range(0, 2));
    end

    // Reset during a serialized store: only lane 0's write can land.
    @(negedge clk);
    req_valid = 1'b1; req_store = 1'b1; req_mask = 4'hF;
    for (int l = 0; l < LANES; l++) begin
      req_addr[l*LAW +: LAW] = 7'(4*(20 + l));
      req_wdata[l*DW +: DW]  = 16'(16'hC0 + l);
    end
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    check("mid_issue_en", 64'(bank_write_en), 64'd1);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("mid_rst_bank_en", 64'(bank_write_en), 64'd0);
    check("mid_rst_req_ready", 64'(req_ready), 64'd1);
    check("mid_rst_resp_valid", 64'(resp_valid), 64'd0);
    rst_n = 1'b1;
    gm[80] = 16'hC0;
    repeat (3) begin
      @(negedge clk);
      check("post_rst_bank_en", 64'(bank_write_en), 64'd0);
    end
    for (int l = 0; l < 4; l++) a[l] = 7'(4*(20 + l));
    run_req(1'b0, 4'hF, a, d, 0);

    report();
  end
endmodule

// File: doc/shared_mem_lsu.md
Name: shared_mem_lsu

Overview:
- Warp-side load/store initiator for the banked shared memory.
- Accepts one LANES-wide warp request (load or store) and splits each lane address into bank index and row.
- Drives the NUM_BANKS shared memory subunit ports and serializes bank conflicts over successive cycles.
- Collects the one-cycle-latency read data and returns a single warp response.

Parameters:
- LANES, 4, number of lanes per warp request
- NUM_BANKS, 4, number of shared memory subunits (banks)
- BANK_BITS, 2, log2(NUM_BANKS)
- BLOCK_SIZE, 32, words per bank
- ADDRESS_WIDTH, 5, row address width per bank
- DATA_WIDTH, 16, word width

Ports:
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  synchronous active-low reset
- req_valid  in  1  warp request valid
- req_ready  out  1  block can accept a request
- req_store  in  1  1 = store, 0 = load
- req_mask  in  LANES  active-lane mask
- req_addr  in  LANES*(ADDRESS_WIDTH+BANK_BITS)  per-lane word address; low BANK_BITS bits = bank, upper bits = row
- req_wdata  in  LANES*DATA_WIDTH  per-lane store data
- resp_valid  out  1  warp response valid
- resp_ready  in  1  response consumer ready
- resp_rdata  out  LANES*DATA_WIDTH  per-lane load data
- resp_cycles  out  8  number of ISSUE cycles used by this request, saturating at 255
- bank_write_en  out  NUM_BANKS  per-bank write enable
- bank_addr  out  NUM_BANKS*ADDRESS_WIDTH  per-bank row address
- bank_write_data  out  NUM_BANKS*DATA_WIDTH  per-bank write data
- bank_read_data  in  NUM_BANKS*DATA_WIDTH  per-bank read data, registered by the bank one cycle after bank_addr

Behaviour:
- Reset (rst_n low at a clk edge):
  - state goes to IDLE; pending and capture masks cleared.
  - req_ready=1; resp_valid=0; resp_rdata=0; resp_cycles=0; bank_write_en=0; bank_addr=0; bank_write_data=0.
  - Reset mid-request abandons the request; no further bank writes occur.
- States: IDLE, ISSUE, DRAIN, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid, latch store flag, mask, addrs and wdata; set pending=req_mask; clear resp_rdata and resp_cycles.
  - If req_mask==0, go to RESP; otherwise go to ISSUE.
- ISSUE, each cycle:
  - Per bank b, the winner is the lowest-index pending lane whose bank field is b.
  - Drive bank_addr[b] with the winner's row.
  - For stores, also drive bank_write_en[b]=1 and bank_write_data[b] with the winner's data.
  - Grant set: for loads, all pending lanes with the same bank and row as the winner (broadcast); for stores, the winner only.
  - Clear the granted lanes from pending; increment resp_cycles (saturating).
  - Banks with no pending lane: write_en=0, addr=0.
- ISSUE exit: when pending becomes 0 after this cycle, loads go to DRAIN and stores go to RESP.
- Load capture:
  - The granted lanes and their bank index are registered into a capture mask.
  - In the following cycle, each captured lane's resp_rdata is loaded from bank_read_data of its bank.
  - Capture happens in ISSUE or DRAIN; DRAIN lasts exactly one cycle, then the block goes to RESP.
- RESP:
  - resp_valid=1; resp_rdata and resp_cycles are held stable.
  - On resp_ready, go to IDLE; resp_valid drops the next cycle.
  - req_ready=0 in every state except IDLE, so there is no overlap between requests.
- Stores to the same bank and same row are serialized lowest lane first, so the highest active lane's data remains in memory.
- Inactive lanes and all store responses return rdata=0.
- Latency from the acceptance edge (request accepted in cycle 0):
  - Conflict-free load: resp_valid in cycle 3.
  - Conflict-free store: resp_valid in cycle 2.
  - Each additional serialization cycle adds 1.
- Worst case: all LANES active on one bank with distinct rows gives LANES ISSUE cycles.
- resp_cycles for an empty mask is 0.

Test Plan:
- Store lanes 0..3 to addrs 0,1,2,3 with data 0xA0..0xA3 -> one ISSUE cycle; all four bank_write_en set in the same cycle; resp_valid in cycle 2; resp_cycles=1.
- Load addrs 0,1,2,3 after the previous store -> resp_rdata={0xA3,0xA2,0xA1,0xA0}; resp_valid in cycle 3; resp_cycles=1.
- Load addrs 0,4,8,12 (all bank 0, rows 0..3) -> bank_addr[0] sequence 0,1,2,3 over four cycles; resp_cycles=4; lane data correct per row.
- Load addrs 5,5,5,5 -> single broadcast ISSUE; all lanes return the same word; resp_cycles=1.
- Store addrs 6,6 on lanes 0 and 1 with data 0x11,0x22 -> two write cycles; a subsequent load of addr 6 returns 0x22.
- req_mask=0 -> RESP with no bank activity and resp_cycles=0. Additionally, hold resp_ready=0 for 5 cycles -> resp_valid and data stable and req_ready=0. Assert rst_n=0 mid-ISSUE -> next cycle bank_write_en=0, req_ready=1, resp_valid=0.
